// File: rtl/serial_nibble_adder_16bit_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package serial_nibble_adder_16bit_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_nibble_adder_16bit_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
interface serial_nibble_adder_16bit_if
  import serial_nibble_adder_16bit_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/serial_nibble_adder_16bit_slice.sv
// Combinational 4-bit adder slice reused on every RUN cycle.
module nibble_adder_slice
  import serial_nibble_adder_16bit_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_nibble_adder_16bit.sv
// Nibble-serial W-bit adder: one 4-bit slice per cycle, result held until taken.
module serial_nibble_adder_16bit
  import serial_nibble_adder_16bit_pkg::*;
#(
  parameter int NIBBLES = 4
)(
  input  logic                        clk,
  input  logic                        rst_n,
  serial_nibble_adder_16bit_if.slave  bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [W-1:0]        sum_q;
  logic                cout_q;
  logic                ovf_q;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  always_comb begin
    slice_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
    slice_b = b_q[idx*NIBBLE_W +: NIBBLE_W];
  end

  nibble_adder_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
            sum_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*NIBBLE_W +: NIBBLE_W] <= slice_sum;
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            state  <= DONE;
            cout_q <= slice_cout;
            // Final MSB comes straight from the slice; sum_q is not yet updated.
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (slice_sum[NIBBLE_W-1] != a_q[W-1]);
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_nibble_adder_16bit.sv
// Scoreboard bench for the nibble-serial adder: expected results queued at accept.
module tb_serial_nibble_adder_16bit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_nibble_adder_16bit_if #(.NIBBLES(4)) bus ();

  serial_nibble_adder_16bit #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    exp_t        e;
    logic [16:0] t;
    t      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.sum  = t[15:0];
    e.cout = t[16];
    e.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
    return e;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input int hold, input bit poke);
    exp_t e;
    int   lat;
    check("in_ready_idle", bus.in_ready, 1);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    sb.push_back(model(a, b, cin));
    @(posedge clk); #1;
    check("in_ready_busy", bus.in_ready, 0);
    if (poke) begin
      bus.a   = 16'hAAAA;
      bus.b   = 16'h5555;
      bus.cin = ~cin;
    end else begin
      bus.in_valid = 1'b0;
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check("latency", lat, 4);
    check("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sum", bus.sum, e.sum);
      check("cout", bus.cout, e.cout);
      check("ovf", bus.ovf, e.ovf);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("out_valid_hold", bus.out_valid, 1);
        check("in_ready_hold", bus.in_ready, 0);
        check("sum_hold", bus.sum, e.sum);
        check("cout_hold", bus.cout, e.cout);
        check("ovf_hold", bus.ovf, e.ovf);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("out_valid_after", bus.out_valid, 0);
      check("in_ready_after", bus.in_ready, 1);
      check("sum_retained", bus.sum, e.sum);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);
    #8 rst_n = 1'b1;

    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0, 3, 1'b0);

    // Reset in the second RUN cycle: operation must vanish.
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_sum", bus.sum, 0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen |= bus.out_valid;
    end
    check("post_rst_no_valid", seen, 0);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_sum", bus.sum, 0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
